add_accum_lanes: RTL and testbench
==================================

Name: add_accum_lanes

Overview:
- Parametrised multi-lane fixed-point add/subtract accumulator for the dynamics datapath. Typical use: summing per-link contributions across joints.
- Accepts a framed stream of LANES operand vectors. Each beat is added to or subtracted from a per-lane running sum, with optional saturation and per-lane overflow flags.
- Presents one registered result vector per frame on a valid/ready output.

Parameters:
- WIDTH, 32, total bits per fixed-point lane value (two's complement)
- DECIMAL_BITS, 16, fractional bits. Informational only; the arithmetic does not depend on it.
- LANES, 7, number of independent lanes
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_first  input  1  beat starts a new frame
- in_last  input  1  beat ends the frame
- in_sub  input  1  1 = subtract a_in, 0 = add a_in (applies to all lanes of the beat)
- a_in  input  LANES*WIDTH  operand vector; lane i = bits [i*WIDTH +: WIDTH]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum_out  output  LANES*WIDTH  registered frame result, same packing as a_in
- ovf_out  output  LANES  per-lane sticky overflow for the presented frame

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n.
- Reset effects: out_valid=0, sum_out=0, ovf_out=0, accumulators=0, state=IDLE.
  - in_ready=0 while rst_n=0.
  - Reset mid-frame discards any partial sum and any pending result.
- Handshakes:
  - Input beat accepted when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = rst_n & (~out_valid | out_ready), so a same-cycle drain and new accept is allowed.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, partial sums held.
- Transitions:
  - IDLE, accepted beat with in_last=0 -> ACCUM.
  - IDLE, accepted beat with in_last=1 -> IDLE, result registered.
  - ACCUM, accepted beat with in_last=1 -> IDLE, result registered.
  - ACCUM, accepted beat with in_first=1 -> frame restarts. Partial sums and ovf are discarded; the beat is treated as a first beat.
  - IDLE, accepted beat without in_first -> treated as a first beat.
- Per-lane arithmetic:
  - base = 0 on a first beat, otherwise acc.
  - Compute t = sext(base) ± sext(a) in WIDTH+1 bits.
  - Overflow when t[WIDTH] != t[WIDTH-1].
  - With overflow and SATURATE=1, result = 0x7FF..F if t is positive, 0x800..0 if negative.
  - With overflow and SATURATE=0, result = t[WIDTH-1:0].
  - Subtracting the most-negative value is computed in WIDTH+1 bits, so it is flagged rather than mis-signed.
  - ovf for the lane = overflow on this beat | (sticky ovf unless first beat).
- Saturation applies per beat. A clamped partial sum continues accumulating from the clamped value.
- Latency: out_valid rises the cycle after the last beat is accepted. sum_out/ovf_out update only on that edge.
- Held output: sum_out and ovf_out remain stable while out_valid & ~out_ready.
- out_valid clears on transfer unless a new last beat is accepted in the same cycle, in which case it stays 1 with new data.
- Throughput: one single-beat frame per cycle when out_ready=1.
- No combinational path from a_in to any output. in_ready depends combinationally only on out_valid, out_ready and rst_n.

Test Plan:
(WIDTH=32, DECIMAL_BITS=16, LANES=7)
- Lane0 frame, three beats: +0x00010000, +0x00028000, sub 0x00008000, first/last on the end beats -> one cycle after the last beat, out_valid=1, lane0=0x00030000, ovf_out=0. Other lanes hold their own independent sums.
- SATURATE=1: 0x7FFF0000 + 0x00020000 -> lane0=0x7FFFFFFF, ovf bit0=1.
  - Rerun with SATURATE=0 -> lane0=0x80010000, ovf bit0=1.
  - Then a new frame of +0x00010000 -> 0x00010000, ovf=0.
- Single-beat frame 0 - 0x80000000 (in_sub=1) -> 0x7FFFFFFF, ovf=1 (SATURATE=1).
- Backpressure:
  - Hold out_ready=0 for 3 cycles with a result pending -> in_ready=0, sum_out/ovf_out stable.
  - Raise out_ready with a new last beat presented -> transfer and accept in the same cycle; out_valid stays 1 with the new sum.
- Back-to-back single-beat frames for 10 cycles, out_ready=1 -> 10 results on 10 consecutive cycles, each equal to ±a_in.
- Restart and reset mid-frame:
  - Two beats +0x00010000 then a beat with in_first=1, a=0x00050000, in_last=1 -> result 0x00050000.
  - Repeat with rst_n=0 for 1 cycle after the two beats -> no output. The next frame excludes the pre-reset beats.

Source files
------------

// File: rtl/add_accum_lanes_if.sv
// Valid/ready bundle for the multi-lane add/subtract accumulator.
// The master drives operand beats and result acceptance; the slave answers.
interface add_accum_lanes_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 7
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_first;
    logic                   in_last;
    logic                   in_sub;
    logic [LANES*WIDTH-1:0] a_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] sum_out;
    logic [LANES-1:0]       ovf_out;

    modport master (
        output in_valid, in_first, in_last, in_sub, a_in, out_ready,
        input  in_ready, out_valid, sum_out, ovf_out
    );

    modport slave (
        input  in_valid, in_first, in_last, in_sub, a_in, out_ready,
        output in_ready, out_valid, sum_out, ovf_out
    );
endinterface

// File: rtl/add_accum_lanes.sv
// Framed per-lane fixed-point add/subtract accumulator with optional
// saturation, sticky per-lane overflow and a registered valid/ready result.
module add_accum_lanes #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16,
    parameter int LANES        = 7,
    parameter bit SATURATE     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    add_accum_lanes_if.slave bus
);
    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LANES*WIDTH-1:0] r_acc;
    logic [LANES*WIDTH-1:0] r_sum;
    logic [LANES*WIDTH-1:0] w_res;
    logic [LANES-1:0]       r_sticky;
    logic [LANES-1:0]       r_ovf;
    logic [LANES-1:0]       w_ovf;
    logic                   r_valid;
    logic                   w_accept;
    logic                   w_first;

    if (DECIMAL_BITS < 0 || DECIMAL_BITS >= WIDTH) begin : g_bad_frac
        $error("DECIMAL_BITS must lie in [0, WIDTH)");
    end

    assign bus.in_ready  = rst_n & (~r_valid | bus.out_ready);
    assign bus.out_valid = r_valid;
    assign bus.sum_out   = r_sum;
    assign bus.ovf_out   = r_ovf;

    assign w_accept = bus.in_valid & bus.in_ready;
    // An idle block treats any beat as the start of a frame.
    assign w_first  = bus.in_first | (r_state == IDLE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] w_base;
        logic [WIDTH-1:0] w_a;
        logic [WIDTH:0]   w_t;
        logic             w_ov;

        assign w_base = w_first ? '0 : r_acc[i*WIDTH +: WIDTH];
        assign w_a    = bus.a_in[i*WIDTH +: WIDTH];
        assign w_t    = bus.in_sub
                      ? ({w_base[WIDTH-1], w_base} - {w_a[WIDTH-1], w_a})
                      : ({w_base[WIDTH-1], w_base} + {w_a[WIDTH-1], w_a});
        assign w_ov   = w_t[WIDTH] ^ w_t[WIDTH-1];
        assign w_ovf[i] = w_ov | (~w_first & r_sticky[i]);

        // w_t[WIDTH] is the true sign, so it selects the clamp rail.
        if (SATURATE) begin : g_sat
            assign w_res[i*WIDTH +: WIDTH] = w_ov
                ? {w_t[WIDTH], {(WIDTH-1){~w_t[WIDTH]}}}
                : w_t[WIDTH-1:0];
        end else begin : g_wrap
            assign w_res[i*WIDTH +: WIDTH] = w_t[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = bus.in_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_sticky <= '0;
            r_sum    <= '0;
            r_ovf    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_acc    <= w_res;
                r_sticky <= w_ovf;
            end
            if (w_accept & bus.in_last) begin
                r_valid <= 1'b1;
                r_sum   <= w_res;
                r_ovf   <= w_ovf;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_add_accum_lanes.sv
// Bench for add_accum_lanes: saturating and wrapping instances share one
// stimulus stream; a reference model feeds a result scoreboard.
module tb_add_accum_lanes;
    localparam int W = 32;
    localparam int L = 7;

    typedef logic [L*W-1:0] vec_t;

    typedef struct {
        vec_t         sum;
        logic [L-1:0] ovf;
    } exp_t;

    typedef struct {
        bit           sub;
        logic [W-1:0] a0;
        logic [W-1:0] s0;
        bit           o0;
        logic [W-1:0] w0;
        bit           wo0;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t sb[$];
    int   pop_cyc[$];

    logic [W-1:0] m_acc[L];
    logic [L-1:0] m_ovf;
    bit           m_open = 1'b0;

    add_accum_lanes_if #(.WIDTH(W), .LANES(L)) sif ();
    add_accum_lanes_if #(.WIDTH(W), .LANES(L)) wif ();

    assign wif.in_valid  = sif.in_valid;
    assign wif.in_first  = sif.in_first;
    assign wif.in_last   = sif.in_last;
    assign wif.in_sub    = sif.in_sub;
    assign wif.a_in      = sif.a_in;
    assign wif.out_ready = sif.out_ready;

    add_accum_lanes #(
        .WIDTH(W), .DECIMAL_BITS(16), .LANES(L), .SATURATE(1'b1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(sif)
    );

    add_accum_lanes #(
        .WIDTH(W), .DECIMAL_BITS(16), .LANES(L), .SATURATE(1'b0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(wif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: 64-bit signed arithmetic with explicit clamping.
    task automatic model_beat(input bit first, input bit last,
                              input bit sub, input vec_t a);
        bit     f;
        longint base;
        longint av;
        longint s;
        bit     ov;
        exp_t   e;
        f = first || !m_open;
        for (int i = 0; i < L; i++) begin
            base = f ? 64'sd0 : longint'($signed(m_acc[i]));
            av   = longint'($signed(a[i*W +: W]));
            s    = sub ? base - av : base + av;
            ov   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            if (ov) m_acc[i] = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            else    m_acc[i] = s[W-1:0];
            m_ovf[i] = ov | (!f && m_ovf[i]);
        end
        if (last) begin
            for (int i = 0; i < L; i++) e.sum[i*W +: W] = m_acc[i];
            e.ovf = m_ovf;
            sb.push_back(e);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic send_beat(input bit first, input bit last,
                             input bit sub, input vec_t a);
        int n;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b1;
        sif.in_first = first;
        sif.in_last  = last;
        sif.in_sub   = sub;
        sif.a_in     = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (sif.in_ready) begin
                model_beat(first, last, sub, a);
                break;
            end
            n++;
            if (n > 50) begin
                n_total++;
                $display("FAIL send_timeout: in_ready low for %0d cycles", n);
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        sif.in_first = 1'b0;
        sif.in_last  = 1'b0;
        sif.in_sub   = 1'b0;
    endtask

    function automatic vec_t mkv(input logic [W-1:0] l0);
        vec_t v;
        v[W-1:0] = l0;
        for (int i = 1; i < L; i++) v[i*W +: W] = $urandom_range(0, 32'h000F_FFFF);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && sif.out_valid && sif.out_ready) begin
            exp_t e;
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: result %h with empty queue",
                         sif.sum_out[W-1:0]);
            end else begin
                e = sb.pop_front();
                chk("sb_sum", sif.sum_out, e.sum);
                chk("sb_ovf", sif.ovf_out, e.ovf);
            end
        end
    end

    rec_t tbl[6];

    initial begin
        int   n_out;
        vec_t vb;

        tbl[0] = '{0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0001_0000, 0};
        tbl[1] = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h8000_0000, 1};
        tbl[2] = '{1, 32'h0001_0000, 32'hFFFF_0000, 0, 32'hFFFF_0000, 0};
        tbl[3] = '{0, 32'h8000_0000, 32'h8000_0000, 0, 32'h8000_0000, 0};
        tbl[4] = '{1, 32'h7FFF_FFFF, 32'h8000_0001, 0, 32'h8000_0001, 0};
        tbl[5] = '{0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0};

        sif.in_valid  = 1'b0;
        sif.in_first  = 1'b0;
        sif.in_last   = 1'b0;
        sif.in_sub    = 1'b0;
        sif.a_in      = '0;
        sif.out_ready = 1'b1;
        m_ovf         = '0;
        for (int i = 0; i < L; i++) m_acc[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", sif.in_ready, 0);
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_sum", sif.sum_out, 0);
        chk("rst_ovf", sif.ovf_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", sif.in_ready, 1);

        // Three-beat frame with independent lanes.
        send_beat(1, 0, 0, mkv(32'h0001_0000));
        send_beat(0, 0, 0, mkv(32'h0002_8000));
        send_beat(0, 1, 1, mkv(32'h0000_8000));
        idle();
        @(negedge clk);
        chk("frame3_valid", sif.out_valid, 1);
        chk("frame3_lane0", sif.sum_out[W-1:0], 32'h0003_0000);
        chk("frame3_ovf", sif.ovf_out, 0);

        // Single-beat table on both saturating and wrapping instances.
        for (int k = 0; k < 6; k++) begin
            send_beat(1, 1, tbl[k].sub, mkv(tbl[k].a0));
            idle();
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), sif.out_valid, 1);
            chk($sformatf("tbl%0d_sat", k), sif.sum_out[W-1:0], tbl[k].s0);
            chk($sformatf("tbl%0d_sat_ovf", k), sif.ovf_out[0], tbl[k].o0);
            chk($sformatf("tbl%0d_wrap", k), wif.sum_out[W-1:0], tbl[k].w0);
            chk($sformatf("tbl%0d_wrap_ovf", k), wif.ovf_out[0], tbl[k].wo0);
        end

        // Two-beat overflow, then a clean frame clears the flag.
        send_beat(1, 0, 0, mkv(32'h7FFF_0000));
        send_beat(0, 1, 0, mkv(32'h0002_0000));
        idle();
        @(negedge clk);
        chk("sat_lane0", sif.sum_out[W-1:0], 32'h7FFF_FFFF);
        chk("sat_ovf0", sif.ovf_out[0], 1);
        chk("wrap_lane0", wif.sum_out[W-1:0], 32'h8001_0000);
        chk("wrap_ovf0", wif.ovf_out[0], 1);
        send_beat(1, 1, 0, mkv(32'h0001_0000));
        idle();
        @(negedge clk);
        chk("clean_sat_lane0", sif.sum_out[W-1:0], 32'h0001_0000);
        chk("clean_sat_ovf0", sif.ovf_out[0], 0);
        chk("clean_wrap_lane0", wif.sum_out[W-1:0], 32'h0001_0000);
        chk("clean_wrap_ovf0", wif.ovf_out[0], 0);

        // Backpressure: hold a result, then drain and accept together.
        repeat (2) @(negedge clk);
        sif.out_ready = 1'b0;
        send_beat(1, 1, 0, mkv(32'h0012_3400));
        vb = mkv(32'h0000_4000);
        fork
            send_beat(1, 1, 1, vb);
        join_none
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", sif.in_ready, 0);
            chk("bp_valid", sif.out_valid, 1);
            chk("bp_sum_held", sif.sum_out, sb[0].sum);
            chk("bp_ovf_held", sif.ovf_out, sb[0].ovf);
        end
        @(posedge clk);
        #1 sif.out_ready = 1'b1;
        wait fork;
        idle();
        @(negedge clk);
        chk("bp_refill_valid", sif.out_valid, 1);
        chk("bp_refill_lane0", sif.sum_out[W-1:0], 32'hFFFF_C000);

        // Back-to-back single-beat frames.
        repeat (3) @(negedge clk);
        pop_cyc.delete();
        for (int k = 0; k < 10; k++) begin
            send_beat(1, 1, 1'($urandom_range(0, 1)), mkv($urandom));
        end
        idle();
        repeat (3) @(negedge clk);
        chk("b2b_count", pop_cyc.size(), 10);
        if (pop_cyc.size() == 10) chk("b2b_span", pop_cyc[9] - pop_cyc[0], 9);

        // Restart mid-frame.
        send_beat(1, 0, 0, mkv(32'h0001_0000));
        send_beat(0, 0, 0, mkv(32'h0001_0000));
        send_beat(1, 1, 0, mkv(32'h0005_0000));
        idle();
        @(negedge clk);
        chk("restart_lane0", sif.sum_out[W-1:0], 32'h0005_0000);
        chk("restart_ovf", sif.ovf_out, 0);

        // Reset mid-frame.
        send_beat(1, 0, 0, mkv(32'h0001_0000));
        send_beat(0, 0, 0, mkv(32'h0001_0000));
        idle();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", sif.in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_open = 1'b0;
        n_out = 0;
        repeat (3) begin
            @(negedge clk);
            if (sif.out_valid) n_out++;
        end
        chk("midrst_no_output", n_out, 0);
        send_beat(0, 1, 0, mkv(32'h0002_0000));
        idle();
        @(negedge clk);
        chk("postrst_valid", sif.out_valid, 1);
        chk("postrst_lane0", sif.sum_out[W-1:0], 32'h0002_0000);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
